// File: rtl/lpm_add_sub_pipe.sv
// Parameterised adder/subtractor with optional output pipeline.
// Arithmetic is combinational on the inputs; result, flags and valid tag then ride LPM_PIPELINE stages.
module lpm_add_sub_pipe #(
    parameter int    LPM_WIDTH          = 8,
    parameter int    LPM_PIPELINE       = 2,
    parameter string LPM_REPRESENTATION = "UNSIGNED",
    parameter string LPM_DIRECTION      = "UNUSED"
) (
    input  logic                 clock,
    input  logic                 aclr,
    input  logic                 clken,
    input  logic                 add_sub,
    input  logic                 cin,
    input  logic [LPM_WIDTH-1:0] dataa,
    input  logic [LPM_WIDTH-1:0] datab,
    input  logic                 in_valid,
    output logic [LPM_WIDTH-1:0] result,
    output logic                 cout,
    output logic                 overflow,
    output logic                 out_valid
);

    localparam int SW        = LPM_WIDTH + 3;
    localparam bit IS_SIGNED = (LPM_REPRESENTATION == "SIGNED");
    localparam bit FORCE_ADD = (LPM_DIRECTION == "ADD");
    localparam bit FORCE_SUB = (LPM_DIRECTION == "SUB");

    logic                 do_add;
    logic [LPM_WIDTH-1:0] b_eff;
    logic [LPM_WIDTH:0]   sum;
    logic                 comb_ovf;
    logic [SW-1:0]        comb_word;
    logic [SW-1:0]        out_word;

    // Subtraction is dataa + ~datab + cin, so cin doubles as an active-low borrow-in.
    always_comb begin
        do_add = add_sub;
        if (FORCE_ADD) begin
            do_add = 1'b1;
        end else if (FORCE_SUB) begin
            do_add = 1'b0;
        end
        b_eff = do_add ? datab : ~datab;
        sum   = {1'b0, dataa} + {1'b0, b_eff} + {{LPM_WIDTH{1'b0}}, cin};
        if (IS_SIGNED) begin
            comb_ovf = (dataa[LPM_WIDTH-1] == b_eff[LPM_WIDTH-1]) &&
                       (sum[LPM_WIDTH-1] != dataa[LPM_WIDTH-1]);
        end else begin
            comb_ovf = do_add ? sum[LPM_WIDTH] : ~sum[LPM_WIDTH];
        end
        comb_word = {in_valid, comb_ovf, sum[LPM_WIDTH], sum[LPM_WIDTH-1:0]};
    end

    generate
        if (LPM_PIPELINE == 0) begin : g_comb
            assign out_word = comb_word;
        end else begin : g_pipe
            logic [SW-1:0] stage_q [LPM_PIPELINE];
            logic [SW-1:0] stage_d [LPM_PIPELINE];

            always_comb begin
                stage_d[0] = comb_word;
                for (int i = 1; i < LPM_PIPELINE; i++) begin
                    stage_d[i] = stage_q[i-1];
                end
            end

            // in_valid only tags the word; every stage advances on any enabled edge.
            always_ff @(posedge clock or posedge aclr) begin
                if (aclr) begin
                    for (int i = 0; i < LPM_PIPELINE; i++) begin
                        stage_q[i] <= '0;
                    end
                end else if (clken) begin
                    for (int i = 0; i < LPM_PIPELINE; i++) begin
                        stage_q[i] <= stage_d[i];
                    end
                end
            end

            assign out_word = stage_q[LPM_PIPELINE-1];
        end
    endgenerate

    assign result    = out_word[LPM_WIDTH-1:0];
    assign cout      = out_word[LPM_WIDTH];
    assign overflow  = out_word[LPM_WIDTH+1];
    assign out_valid = out_word[LPM_WIDTH+2];

endmodule

// File: tb/tb_lpm_add_sub_pipe.sv
// Directed bench for lpm_add_sub_pipe: four instances (unsigned, signed, forced-SUB, zero-latency) share one stimulus set.
module tb_lpm_add_sub_pipe;

    logic       clock = 1'b0;
    logic       aclr;
    logic       clken;
    logic       add_sub;
    logic       cin;
    logic [7:0] dataa;
    logic [7:0] datab;
    logic       in_valid;

    logic [7:0] res_u, res_s, res_d, res_c;
    logic       cout_u, cout_s, cout_d, cout_c;
    logic       ovf_u, ovf_s, ovf_d, ovf_c;
    logic       vld_u, vld_s, vld_d, vld_c;

    int checks = 0;
    int errors = 0;

    // Observation words laid out as {out_valid, overflow, cout, result}.
    wire [10:0] obs_u = {vld_u, ovf_u, cout_u, res_u};
    wire [10:0] obs_s = {vld_s, ovf_s, cout_s, res_s};
    wire [10:0] obs_d = {vld_d, ovf_d, cout_d, res_d};
    wire [10:0] obs_c = {vld_c, ovf_c, cout_c, res_c};

    always #5 clock = ~clock;

    lpm_add_sub_pipe #(.LPM_WIDTH(8), .LPM_PIPELINE(2), .LPM_REPRESENTATION("UNSIGNED"), .LPM_DIRECTION("UNUSED")) u_dut (
        .clock(clock), .aclr(aclr), .clken(clken), .add_sub(add_sub), .cin(cin),
        .dataa(dataa), .datab(datab), .in_valid(in_valid),
        .result(res_u), .cout(cout_u), .overflow(ovf_u), .out_valid(vld_u));

    lpm_add_sub_pipe #(.LPM_WIDTH(8), .LPM_PIPELINE(2), .LPM_REPRESENTATION("SIGNED"), .LPM_DIRECTION("UNUSED")) u_signed (
        .clock(clock), .aclr(aclr), .clken(clken), .add_sub(add_sub), .cin(cin),
        .dataa(dataa), .datab(datab), .in_valid(in_valid),
        .result(res_s), .cout(cout_s), .overflow(ovf_s), .out_valid(vld_s));

    lpm_add_sub_pipe #(.LPM_WIDTH(8), .LPM_PIPELINE(2), .LPM_REPRESENTATION("UNSIGNED"), .LPM_DIRECTION("SUB")) u_sub (
        .clock(clock), .aclr(aclr), .clken(clken), .add_sub(add_sub), .cin(cin),
        .dataa(dataa), .datab(datab), .in_valid(in_valid),
        .result(res_d), .cout(cout_d), .overflow(ovf_d), .out_valid(vld_d));

    lpm_add_sub_pipe #(.LPM_WIDTH(8), .LPM_PIPELINE(0), .LPM_REPRESENTATION("UNSIGNED"), .LPM_DIRECTION("UNUSED")) u_comb (
        .clock(clock), .aclr(aclr), .clken(clken), .add_sub(add_sub), .cin(cin),
        .dataa(dataa), .datab(datab), .in_valid(in_valid),
        .result(res_c), .cout(cout_c), .overflow(ovf_c), .out_valid(vld_c));

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic c,
                         input logic as, input logic v);
        dataa    = a;
        datab    = b;
        cin      = c;
        add_sub  = as;
        in_valid = v;
    endtask

    task automatic test_reset();
        aclr  = 1'b1;
        clken = 1'b1;
        drive(8'hA5, 8'h5A, 1'b1, 1'b1, 1'b1);
        #1;
        checks++;
        if (obs_u !== 11'h000) begin
            errors++;
            $display("[TB] FAIL reset_async: got %h expected %h", obs_u, 11'h000);
        end
        step();
        checks++;
        if (obs_u !== 11'h000) begin
            errors++;
            $display("[TB] FAIL reset_over_clken: got %h expected %h", obs_u, 11'h000);
        end
        aclr = 1'b0;
        drive(8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        step();
        step();
    endtask

    task automatic test_unsigned_add();
        drive(8'hF0, 8'h20, 1'b0, 1'b1, 1'b1);
        step();
        drive(8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        checks++;
        if (vld_u !== 1'b0) begin
            errors++;
            $display("[TB] FAIL uadd_latency1: got %b expected %b", vld_u, 1'b0);
        end
        step();
        checks++;
        if (obs_u !== {1'b1, 1'b1, 1'b1, 8'h10}) begin
            errors++;
            $display("[TB] FAIL uadd: got %h expected %h", obs_u, {1'b1, 1'b1, 1'b1, 8'h10});
        end
        step();
        checks++;
        if (vld_u !== 1'b0) begin
            errors++;
            $display("[TB] FAIL uadd_single_pulse: got %b expected %b", vld_u, 1'b0);
        end
    endtask

    task automatic test_subtract();
        drive(8'h05, 8'h07, 1'b1, 1'b0, 1'b1);
        step();
        step();
        checks++;
        if (obs_u !== {1'b1, 1'b1, 1'b0, 8'hFE}) begin
            errors++;
            $display("[TB] FAIL usub: got %h expected %h", obs_u, {1'b1, 1'b1, 1'b0, 8'hFE});
        end
        checks++;
        if (obs_s !== {1'b1, 1'b0, 1'b0, 8'hFE}) begin
            errors++;
            $display("[TB] FAIL ssub: got %h expected %h", obs_s, {1'b1, 1'b0, 1'b0, 8'hFE});
        end
    endtask

    task automatic test_signed_add();
        drive(8'h7F, 8'h01, 1'b0, 1'b1, 1'b1);
        step();
        drive(8'hFF, 8'h01, 1'b0, 1'b1, 1'b1);
        step();
        drive(8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        checks++;
        if (obs_s !== {1'b1, 1'b1, 1'b0, 8'h80}) begin
            errors++;
            $display("[TB] FAIL sadd_pos_ovf: got %h expected %h", obs_s, {1'b1, 1'b1, 1'b0, 8'h80});
        end
        checks++;
        if (obs_u !== {1'b1, 1'b0, 1'b0, 8'h80}) begin
            errors++;
            $display("[TB] FAIL uadd_no_ovf: got %h expected %h", obs_u, {1'b1, 1'b0, 1'b0, 8'h80});
        end
        step();
        checks++;
        if (obs_s !== {1'b1, 1'b0, 1'b1, 8'h00}) begin
            errors++;
            $display("[TB] FAIL sadd_wrap: got %h expected %h", obs_s, {1'b1, 1'b0, 1'b1, 8'h00});
        end
        step();
    endtask

    task automatic test_direction_sub();
        drive(8'h10, 8'h03, 1'b1, 1'b1, 1'b1);
        step();
        drive(8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        step();
        checks++;
        if (obs_d !== {1'b1, 1'b0, 1'b1, 8'h0D}) begin
            errors++;
            $display("[TB] FAIL dir_sub: got %h expected %h", obs_d, {1'b1, 1'b0, 1'b1, 8'h0D});
        end
        checks++;
        if (obs_u !== {1'b1, 1'b0, 1'b0, 8'h14}) begin
            errors++;
            $display("[TB] FAIL dir_unused_add: got %h expected %h", obs_u, {1'b1, 1'b0, 1'b0, 8'h14});
        end
        step();
    endtask

    task automatic test_back_to_back();
        drive(8'h10, 8'h05, 1'b0, 1'b1, 1'b1);
        step();
        drive(8'h10, 8'h05, 1'b1, 1'b0, 1'b1);
        step();
        checks++;
        if (obs_u !== {1'b1, 1'b0, 1'b0, 8'h15}) begin
            errors++;
            $display("[TB] FAIL b2b_op1: got %h expected %h", obs_u, {1'b1, 1'b0, 1'b0, 8'h15});
        end
        drive(8'h01, 8'h01, 1'b1, 1'b1, 1'b1);
        step();
        checks++;
        if (obs_u !== {1'b1, 1'b0, 1'b1, 8'h0B}) begin
            errors++;
            $display("[TB] FAIL b2b_op2: got %h expected %h", obs_u, {1'b1, 1'b0, 1'b1, 8'h0B});
        end
        drive(8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        step();
        checks++;
        if (obs_u !== {1'b1, 1'b0, 1'b0, 8'h03}) begin
            errors++;
            $display("[TB] FAIL b2b_op3: got %h expected %h", obs_u, {1'b1, 1'b0, 1'b0, 8'h03});
        end
        step();
        checks++;
        if (vld_u !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_drain: got %b expected %b", vld_u, 1'b0);
        end
    endtask

    task automatic test_stall();
        drive(8'h12, 8'h34, 1'b0, 1'b1, 1'b1);
        step();
        checks++;
        if (obs_u !== 11'h000) begin
            errors++;
            $display("[TB] FAIL stall_pre: got %h expected %h", obs_u, 11'h000);
        end
        clken = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(8'hFF - 8'(i), 8'hFF, 1'b1, 1'(i), 1'b1);
            step();
            checks++;
            if (obs_u !== 11'h000) begin
                errors++;
                $display("[TB] FAIL stall_hold%0d: got %h expected %h", i, obs_u, 11'h000);
            end
        end
        clken = 1'b1;
        drive(8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        step();
        checks++;
        if (obs_u !== {1'b1, 1'b0, 1'b0, 8'h46}) begin
            errors++;
            $display("[TB] FAIL stall_release: got %h expected %h", obs_u, {1'b1, 1'b0, 1'b0, 8'h46});
        end
        step();
        checks++;
        if (vld_u !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_drain: got %b expected %b", vld_u, 1'b0);
        end
    endtask

    task automatic test_reset_midflight();
        drive(8'h01, 8'h02, 1'b0, 1'b1, 1'b1);
        step();
        drive(8'h03, 8'h04, 1'b0, 1'b1, 1'b1);
        step();
        checks++;
        if (obs_u !== {1'b1, 1'b0, 1'b0, 8'h03}) begin
            errors++;
            $display("[TB] FAIL midrst_op1: got %h expected %h", obs_u, {1'b1, 1'b0, 1'b0, 8'h03});
        end
        #2;
        aclr = 1'b1;
        #1;
        checks++;
        if (obs_u !== 11'h000) begin
            errors++;
            $display("[TB] FAIL midrst_async: got %h expected %h", obs_u, 11'h000);
        end
        drive(8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        step();
        aclr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (vld_u !== 1'b0) begin
                errors++;
                $display("[TB] FAIL midrst_stale%0d: got %b expected %b", i, vld_u, 1'b0);
            end
        end
        drive(8'h20, 8'h22, 1'b0, 1'b1, 1'b1);
        step();
        drive(8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        step();
        checks++;
        if (obs_u !== {1'b1, 1'b0, 1'b0, 8'h42}) begin
            errors++;
            $display("[TB] FAIL midrst_resume: got %h expected %h", obs_u, {1'b1, 1'b0, 1'b0, 8'h42});
        end
    endtask

    task automatic test_zero_latency();
        drive(8'h80, 8'h80, 1'b0, 1'b1, 1'b1);
        #1;
        checks++;
        if (obs_c !== {1'b1, 1'b1, 1'b1, 8'h00}) begin
            errors++;
            $display("[TB] FAIL comb_add: got %h expected %h", obs_c, {1'b1, 1'b1, 1'b1, 8'h00});
        end
        aclr  = 1'b1;
        clken = 1'b0;
        #1;
        checks++;
        if (obs_c !== {1'b1, 1'b1, 1'b1, 8'h00}) begin
            errors++;
            $display("[TB] FAIL comb_ignores_aclr: got %h expected %h", obs_c, {1'b1, 1'b1, 1'b1, 8'h00});
        end
        drive(8'h03, 8'h05, 1'b1, 1'b0, 1'b0);
        #1;
        checks++;
        if (obs_c !== {1'b0, 1'b1, 1'b0, 8'hFE}) begin
            errors++;
            $display("[TB] FAIL comb_sub: got %h expected %h", obs_c, {1'b0, 1'b1, 1'b0, 8'hFE});
        end
        aclr  = 1'b0;
        clken = 1'b1;
    endtask

    initial begin
        test_reset();
        test_unsigned_add();
        test_subtract();
        test_signed_add();
        test_direction_sub();
        test_back_to_back();
        test_stall();
        test_reset_midflight();
        test_zero_latency();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
